// File: rtl/div_radix2_pkg.sv
// Shared widths, FSM encodings and a small sign helper for the radix-2 restoring divider.
package div_radix2_pkg;

    localparam int DW         = 32;
    localparam int DIV_CYCLES = 32;
    localparam int CNT_W      = 5;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    function automatic logic [DW-1:0] condNegate(input logic [DW-1:0] value, input logic neg);
        return neg ? -value : value;
    endfunction

endpackage

// File: rtl/div_radix2_if.sv
// Execute-stage divider handshake: operands and pipeline controls in, stall/result out.
interface div_radix2_if;
    import div_radix2_pkg::*;

    logic          start;
    logic          signed_div;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          hold;
    logic          cancel;
    logic          stall_divE;
    logic          ready;
    logic [DW-1:0] hi;
    logic [DW-1:0] lo;

    modport master (
        output start, signed_div, a, b, hold, cancel,
        input  stall_divE, ready, hi, lo
    );

    modport slave (
        input  start, signed_div, a, b, hold, cancel,
        output stall_divE, ready, hi, lo
    );

endinterface

// File: rtl/div_radix2_step.sv
// One restoring division iteration: shift {r, q} left, subtract the divisor, keep it if it fits.
module div_step
    import div_radix2_pkg::*;
(
    input  logic [DW-1:0] rem_i,
    input  logic [DW-1:0] quo_i,
    input  logic [DW-1:0] divisor_i,
    output logic [DW-1:0] rem_o,
    output logic [DW-1:0] quo_o
);

    logic [DW:0] shifted;
    logic [DW:0] trial;
    logic        fits;

    // A shifted remainder with its top bit set always exceeds any DW-bit divisor,
    // otherwise the borrow of the DW+1 bit subtract decides.
    always_comb begin
        shifted = {rem_i, quo_i[DW-1]};
        trial   = shifted - {1'b0, divisor_i};
        fits    = shifted[DW] | ~trial[DW];
        rem_o   = fits ? trial[DW-1:0] : shifted[DW-1:0];
        quo_o   = {quo_i[DW-2:0], fits};
    end

endmodule

// File: rtl/div_radix2.sv
// Multi-cycle radix-2 restoring divider for the E stage; hi = remainder, lo = quotient.
module div_radix2
    import div_radix2_pkg::*;
(
    input  logic clk,
    input  logic rst,
    div_radix2_if.slave bus
);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [DW-1:0]    rem_q, rem_d;
    logic [DW-1:0]    quo_q, quo_d;
    logic [DW-1:0]    divisor_q, divisor_d;
    logic [DW-1:0]    hi_q, hi_d;
    logic [DW-1:0]    lo_q, lo_d;
    logic             negQuo_q, negQuo_d;
    logic             negRem_q, negRem_d;
    logic [DW-1:0]    stepRem, stepQuo;
    logic             negA, negB;

    div_step uStep (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (divisor_q),
        .rem_o     (stepRem),
        .quo_o     (stepQuo)
    );

    assign negA           = bus.signed_div & bus.a[DW-1];
    assign negB           = bus.signed_div & bus.b[DW-1];
    assign bus.stall_divE = bus.start & ~bus.cancel & (state_q != DIV_DONE);
    assign bus.ready      = (state_q == DIV_DONE);
    assign bus.hi         = hi_q;
    assign bus.lo         = lo_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= DIV_IDLE;
            count_q   <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            negQuo_q  <= 1'b0;
            negRem_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            divisor_q <= divisor_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            negQuo_q  <= negQuo_d;
            negRem_q  <= negRem_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        divisor_d = divisor_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        negQuo_d  = negQuo_q;
        negRem_d  = negRem_q;

        case (state_q)
            DIV_IDLE: begin
                if (bus.start) begin
                    negQuo_d  = negA ^ negB;
                    negRem_d  = negA;
                    rem_d     = '0;
                    count_d   = '0;
                    quo_d     = condNegate(bus.a, negA);
                    divisor_d = condNegate(bus.b, negB);
                    // Divide by zero skips iteration with a fixed, recognisable result.
                    if (bus.b == '0) begin
                        lo_d    = '1;
                        hi_d    = bus.a;
                        state_d = DIV_DONE;
                    end else begin
                        state_d = DIV_BUSY;
                    end
                end
            end
            DIV_BUSY: begin
                rem_d   = stepRem;
                quo_d   = stepQuo;
                count_d = count_q + CNT_W'(1);
                if (count_q == CNT_W'(DIV_CYCLES - 1)) begin
                    lo_d    = condNegate(stepQuo, negQuo_q);
                    hi_d    = condNegate(stepRem, negRem_q);
                    state_d = DIV_DONE;
                end
            end
            DIV_DONE: begin
                if (!bus.hold) begin
                    state_d = DIV_IDLE;
                end
            end
            default: begin
                state_d = DIV_IDLE;
            end
        endcase

        // A flush drops any in-flight work and leaves the last committed result alone.
        if (bus.cancel) begin
            state_d = DIV_IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

endmodule

// File: tb/tb_div_radix2.sv
// Directed bench for div_radix2: arithmetic reference model plus per-cycle stall/ready/result checks.
module tb_div_radix2;
    import div_radix2_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    div_radix2_if bus();

    div_radix2 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          total = 0;
    int          bad   = 0;
    bit          checkEn = 1'b0;
    bit          expStall = 1'b0;
    bit          expReady = 1'b0;
    bit          expData  = 1'b0;
    logic [31:0] expHi = '0;
    logic [31:0] expLo = '0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Architectural result: truncating division, remainder takes the dividend's sign.
    function automatic void model(input bit sgn, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] q, output logic [31:0] r);
        longint sx, sy, qq, rr;
        if (y == 32'd0) begin
            q = '1;
            r = x;
        end else if (sgn) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            qq = sx / sy;
            rr = sx % sy;
            q  = qq[31:0];
            r  = rr[31:0];
        end else begin
            q = x / y;
            r = x % y;
        end
    endfunction

    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("stall_divE", {31'b0, bus.stall_divE}, {31'b0, expStall});
            checkOutput("ready", {31'b0, bus.ready}, {31'b0, expReady});
            if (expData) begin
                checkOutput("hi", bus.hi, expHi);
                checkOutput("lo", bus.lo, expLo);
            end
        end
    end

    task automatic cycle(input bit s, input bit r, input bit d);
        expStall = s;
        expReady = r;
        expData  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.start = 1'b0;
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0);
    endtask

    // Issues one divide, scrambles operands while busy, and holds DONE for holdCycles extra cycles.
    task automatic applyStimulus(input bit sgn, input logic [31:0] av, input logic [31:0] bv,
                                 input int holdCycles, input logic [31:0] litLo, input logic [31:0] litHi);
        logic [31:0] mq, mr, capLo, capHi;
        int lat;
        model(sgn, av, bv, mq, mr);
        lat = (bv == 32'd0) ? 1 : 33;
        bus.start      = 1'b1;
        bus.signed_div = sgn;
        bus.a          = av;
        bus.b          = bv;
        bus.cancel     = 1'b0;
        bus.hold       = (holdCycles > 0);
        for (int k = 0; k < lat; k++) begin
            cycle(1'b1, 1'b0, 1'b0);
            bus.a          = ~av;
            bus.b          = bv ^ 32'h5A5A_0001;
            bus.signed_div = ~sgn;
        end
        expLo = mq;
        expHi = mr;
        capLo = bus.lo;
        capHi = bus.hi;
        for (int j = 0; j <= holdCycles; j++) begin
            bus.hold = (j < holdCycles);
            cycle(1'b0, 1'b1, 1'b1);
        end
        bus.hold       = 1'b0;
        bus.a          = av;
        bus.b          = bv;
        bus.signed_div = sgn;
        checkOutput("literal lo", capLo, litLo);
        checkOutput("literal hi", capHi, litHi);
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.signed_div = 1'b0;
        bus.a          = '0;
        bus.b          = '0;
        bus.hold       = 1'b0;
        bus.cancel     = 1'b0;
        rst            = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst     = 1'b0;
        expHi   = '0;
        expLo   = '0;
        checkEn = 1'b1;
        cycle(1'b0, 1'b0, 1'b1);

        applyStimulus(1'b0, 32'd100, 32'd7, 0, 32'd14, 32'd2);
        idle(1);
        applyStimulus(1'b1, 32'hFFFF_FFF9, 32'd2, 0, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        applyStimulus(1'b1, 32'd7, 32'hFFFF_FFFE, 0, 32'hFFFF_FFFD, 32'd1);
        applyStimulus(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h8000_0000, 32'd0);
        idle(1);
        applyStimulus(1'b0, 32'd5, 32'd0, 0, 32'hFFFF_FFFF, 32'd5);
        idle(1);
        applyStimulus(1'b0, 32'hFFFF_FFFF, 32'd1, 4, 32'hFFFF_FFFF, 32'd0);
        idle(1);
        applyStimulus(1'b0, 32'hFFFF_FFFF, 32'h8000_0001, 0, 32'd1, 32'h7FFF_FFFE);
        idle(2);

        // Flush ten cycles into a divide, then restart with a fresh one.
        bus.start      = 1'b1;
        bus.signed_div = 1'b0;
        bus.a          = 32'd1000;
        bus.b          = 32'd3;
        for (int k = 0; k < 10; k++) cycle(1'b1, 1'b0, 1'b0);
        bus.cancel = 1'b1;
        cycle(1'b0, 1'b0, 1'b0);
        bus.cancel = 1'b0;
        bus.start  = 1'b0;
        cycle(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'd9, 32'd3, 0, 32'd3, 32'd0);
        idle(1);

        // Synchronous reset five cycles into a divide clears everything.
        bus.start      = 1'b1;
        bus.signed_div = 1'b0;
        bus.a          = 32'd12345;
        bus.b          = 32'd67;
        for (int k = 0; k < 5; k++) cycle(1'b1, 1'b0, 1'b0);
        rst       = 1'b1;
        bus.start = 1'b0;
        cycle(1'b0, 1'b0, 1'b0);
        rst   = 1'b0;
        expHi = '0;
        expLo = '0;
        cycle(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 0, 32'd14, 32'hFFFF_FFFE);
        idle(2);

        checkEn = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/div_radix2.md
# div_radix2

Multi-cycle 32-bit radix-2 restoring divider in the execute stage. It produces `stall_divE`, which the hazard unit turns into `stallF`/`stallD`/`stallE`. It holds the result until the execute stage actually advances, so that instruction/data-cache stalls do not lose it. Results go to the HI/LO datapath: `hi` is the remainder and `lo` is the quotient.

## Interface
- `DW`, 32: operand width; quotient/remainder width.
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: DIV/DIVU is in E; held high until E advances.
- `signed_div` input 1: 1 = DIV (two's complement), 0 = DIVU; sampled with operands.
- `a` input DW: dividend, already forwarded (forwardAE applied).
- `b` input DW: divisor, already forwarded (forwardBE applied).
- `hold` input 1: E frozen by other causes (`i_stall | d_stall`).
- `cancel` input 1: E-stage flush/exception; aborts the operation.
- `stall_divE` output 1: divider busy; freezes F/D/E.
- `ready` output 1: `hi`/`lo` valid this cycle.
- `hi` output DW: remainder.
- `lo` output DW: quotient.

## Operation
- States:
  - IDLE: stall_divE = start & ~cancel.
  - BUSY: iterating.
  - DONE: result valid, ready = 1.
- IDLE & start & ~cancel:
  - Latch |a|, |b|, sign_q = signed_div & (a[31]^b[31]), sign_r = signed_div & a[31].
  - Clear remainder and count; go to BUSY.
  - If b == 0, go straight to DONE with lo = 0xFFFFFFFF and hi = a (fixed, architecturally undefined).
- BUSY, per cycle, one restoring step:
  - `{r, q} <<= 1`
  - trial = r - |b| (DW+1 bits)
  - if trial is non-negative, r = trial and q[0] = 1.
  - count increments each cycle; after count == DW-1 the state goes to DONE.
- DONE:
  - lo = sign_q ? -q : q; hi = sign_r ? -r : r, registered on entry and stable while in DONE.
  - Go to IDLE when ~hold (E advances); stay in DONE while hold = 1.
- Operands are only sampled at the start. `a`/`b` changes during BUSY are ignored.
- cancel in any state: go to IDLE next cycle; stall_divE = 0 the same cycle; ready = 0 next cycle.
- Outside DONE, stall_divE = start & ~cancel & (state != DONE), so it is 0 in DONE.
- Overflow 0x80000000 / -1 signed: lo = 0x80000000, hi = 0 (natural result of the magnitude path).
- Width rules:
  - Magnitudes are DW-bit unsigned; |0x80000000| = 0x80000000.
  - The trial subtract uses DW+1 bits.

## Timing
- Reset: state = IDLE, count = 0, ready = 0, hi = 0, lo = 0, stall_divE = 0 (given start = 0).
- Start accepted at cycle T:
  - stall_divE high from T through T+32 (33 cycles).
  - BUSY during T+1..T+32.
  - DONE at T+33: ready = 1, stall_divE = 0.
  - E advances at the end of T+33 if hold = 0.
- Divide by zero: DONE at T+1; stall_divE high in T only.
- Back-to-back divides: DONE → IDLE; the next DIV's start is accepted the following cycle. No start is accepted in DONE.
- hold during BUSY has no effect on iteration. hold in DONE extends DONE with the result unchanged.
- Reset or cancel mid-BUSY: IDLE next cycle; partial state is discarded.
- Simultaneous cancel and DONE→IDLE: result is IDLE either way.

## Structure
- Shared defines header:
  - state encodings `DIV_IDLE`, `DIV_BUSY`, `DIV_DONE` (2 bits).
  - `DIV_CYCLES` = 32.
  - count width 5.
- One natural sub-module: `div_step`, a combinational single restoring iteration.
  - Inputs: r, q, |b|.
  - Outputs: next r, next q.
  - Instanced once in BUSY.
- Sign fix-up and the control FSM stay in the top level.

## Test plan
- DIVU 100 / 7 at T → stall_divE high T..T+32; at T+33 ready = 1, lo = 14, hi = 2.
- DIV -7 / 2 → lo = 0xFFFFFFFD, hi = 0xFFFFFFFF; DIV 7 / -2 → lo = 0xFFFFFFFD, hi = 1.
- DIV 0x80000000 / 0xFFFFFFFF → lo = 0x80000000, hi = 0. DIVU 5 / 0 → DONE at T+1, lo = 0xFFFFFFFF, hi = 5.
- DIVU 0xFFFFFFFF / 1 finishing while hold = 1 for 4 cycles → ready stays 1 and lo = 0xFFFFFFFF stays stable for 5 cycles; IDLE after hold drops.
- Disruption mid-operation:
  - cancel at T+10 → stall_divE = 0 that cycle, IDLE at T+11.
  - New DIVU 9 / 3 at T+12 → lo = 3, hi = 0 at T+45.
  - rst at T+5 → all outputs at their reset values next cycle.
